// File: rtl/seg7_serial_ctrl.sv
`default_nettype none
// ============================================================================
// seg7_serial_ctrl : shifts a captured segment word MSB-first into a serial
//                    7-segment chain, strobes the latch, and generates blink.
// Rev 1.0
// ============================================================================
module seg7_serial_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int FLASH_DIV = 25000000,
  parameter int WIDTH     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] seg_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             flash,
  output logic             s_clk,
  output logic             s_dat,
  output logic             s_ld
);

  localparam int c_div_w = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int c_bit_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_fl_w  = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [c_div_w-1:0] c_tick_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_latch_last = c_div_w'(2 * CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(WIDTH - 1);
  localparam logic [c_fl_w-1:0]  c_fl_last    = c_fl_w'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t             r_state, w_state_nx;
  logic [c_div_w-1:0] r_div, w_div_nx;
  logic [c_bit_w-1:0] r_bitcnt, w_bitcnt_nx;
  logic [WIDTH-1:0]   r_shreg, w_shreg_nx;
  logic               r_pending, w_pending_nx;
  logic               w_done_nx;
  logic               w_tick, w_ltick;
  logic [c_fl_w-1:0]  r_fl_cnt;

  assign w_tick  = (r_div == c_tick_last);
  assign w_ltick = (r_div == c_latch_last);

  always_comb begin
    w_state_nx   = r_state;
    w_div_nx     = r_div + 1'b1;
    w_bitcnt_nx  = r_bitcnt;
    w_shreg_nx   = r_shreg;
    w_pending_nx = r_pending;
    w_done_nx    = 1'b0;

    // Requests arriving mid-frame collapse into a single follow-on frame.
    if (r_state != IDLE && start)
      w_pending_nx = 1'b1;

    case (r_state)
      IDLE: begin
        w_div_nx = '0;
        if (start || r_pending) begin
          w_state_nx   = SHIFT_LO;
          w_shreg_nx   = seg_in;
          w_bitcnt_nx  = c_bit_last;
          w_pending_nx = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          w_state_nx = SHIFT_HI;
          w_div_nx   = '0;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          w_div_nx   = '0;
          w_shreg_nx = r_shreg << 1;
          if (r_bitcnt == '0) begin
            w_state_nx = LATCH;
          end else begin
            w_bitcnt_nx = r_bitcnt - 1'b1;
            w_state_nx  = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (w_ltick) begin
          w_state_nx = IDLE;
          w_div_nx   = '0;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Serial outputs are registered from the next state so pins change
  // together with the FSM and never see seg_in/start combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_pending <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_clk     <= 1'b0;
      s_dat     <= 1'b0;
      s_ld      <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_div     <= w_div_nx;
      r_bitcnt  <= w_bitcnt_nx;
      r_shreg   <= w_shreg_nx;
      r_pending <= w_pending_nx;
      busy      <= (w_state_nx != IDLE);
      done      <= w_done_nx;
      s_clk     <= (w_state_nx == SHIFT_HI);
      s_dat     <= ((w_state_nx == SHIFT_LO) || (w_state_nx == SHIFT_HI)) && w_shreg_nx[WIDTH-1];
      s_ld      <= (w_state_nx == LATCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fl_cnt <= '0;
      flash    <= 1'b0;
    end else if (r_fl_cnt == c_fl_last) begin
      r_fl_cnt <= '0;
      flash    <= ~flash;
    end else begin
      r_fl_cnt <= r_fl_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_serial_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg7_serial_ctrl : scoreboard bench with a shift-chain model for two
//                       instances (CLK_DIV=2 and CLK_DIV=1). Rev 1.0
// ============================================================================
module tb_seg7_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] seg_a = '0, seg_b = '0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, done_a, flash_a, sclk_a, sdat_a, sld_a;
  logic        busy_b, done_b, flash_b, sclk_b, sdat_b, sld_b;

  always #5 clk = ~clk;

  seg7_serial_ctrl #(.CLK_DIV(2), .FLASH_DIV(10), .WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .start(start_a), .busy(busy_a),
    .done(done_a), .flash(flash_a), .s_clk(sclk_a), .s_dat(sdat_a), .s_ld(sld_a));

  seg7_serial_ctrl #(.CLK_DIV(1), .FLASH_DIV(10), .WIDTH(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .start(start_b), .busy(busy_b),
    .done(done_b), .flash(flash_b), .s_clk(sclk_b), .s_dat(sdat_b), .s_ld(sld_b));

  int total = 0;
  int bad = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  // Shift-chain model and frame observations for instance A.
  logic [63:0] ch_a = '0;
  logic [63:0] fr_a[$];
  int nr_a[$], bl_a[$], gp_a[$], ld_a[$];
  int nra = 0, bca = 0, lca = 0, idle_a = 0, dn_a = 0;
  logic pa_clk = 0, pa_ld = 0, pa_busy = 0, seen_a = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pa_clk = 0; pa_ld = 0; pa_busy = 0; seen_a = 0;
      nra = 0; bca = 0; lca = 0; idle_a = 0;
    end else begin
      if (busy_a && !pa_busy) begin
        nra = 0;
        if (seen_a) gp_a.push_back(idle_a);
      end
      if (busy_a) bca++;
      else begin
        if (pa_busy) begin bl_a.push_back(bca); bca = 0; seen_a = 1; idle_a = 0; end
        idle_a++;
      end
      if (sclk_a && !pa_clk) begin ch_a = {ch_a[62:0], sdat_a}; nra++; end
      if (sld_a && !pa_ld) begin fr_a.push_back(ch_a); nr_a.push_back(nra); end
      if (sld_a) lca++;
      else if (pa_ld) begin ld_a.push_back(lca); lca = 0; end
      if (done_a) dn_a++;
      pa_clk = sclk_a; pa_ld = sld_a; pa_busy = busy_a;
    end
  end

  // Same observations for instance B, plus first-to-last rise span.
  logic [63:0] ch_b = '0;
  logic [63:0] fr_b[$];
  int nr_b[$], bl_b[$], gp_b[$], sp_b[$];
  int nrb = 0, bcb = 0, idle_b = 0, dn_b = 0, cyc_b = 0, fcyc_b = 0, lcyc_b = 0;
  logic pb_clk = 0, pb_ld = 0, pb_busy = 0, seen_b = 0;

  always @(negedge clk) begin
    cyc_b++;
    if (!rst_n) begin
      pb_clk = 0; pb_ld = 0; pb_busy = 0; seen_b = 0;
      nrb = 0; bcb = 0; idle_b = 0;
    end else begin
      if (busy_b && !pb_busy) begin
        nrb = 0;
        if (seen_b) gp_b.push_back(idle_b);
      end
      if (busy_b) bcb++;
      else begin
        if (pb_busy) begin bl_b.push_back(bcb); bcb = 0; seen_b = 1; idle_b = 0; end
        idle_b++;
      end
      if (sclk_b && !pb_clk) begin
        ch_b = {ch_b[62:0], sdat_b};
        nrb++;
        if (nrb == 1) fcyc_b = cyc_b;
        lcyc_b = cyc_b;
      end
      if (sld_b && !pb_ld) begin
        fr_b.push_back(ch_b); nr_b.push_back(nrb); sp_b.push_back(lcyc_b - fcyc_b);
      end
      if (done_b) dn_b++;
      pb_clk = sclk_b; pb_ld = sld_b; pb_busy = busy_b;
    end
  end

  task automatic wait_dn_a(input int tgt, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      if (dn_a >= tgt) ok = 1;
    end
  endtask

  task automatic wait_dn_b(input int tgt, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      if (dn_b >= tgt) ok = 1;
    end
  endtask

  task automatic test_reset();
    logic want;
    rst_n = 0; start_a = 0; start_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy_a, done_a, flash_a, sclk_a, sdat_a, sld_a} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b want=000000", {busy_a, done_a, flash_a, sclk_a, sdat_a, sld_a});
    end
    @(posedge clk); #1 rst_n = 1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); @(negedge clk);
      want = ((k / 10) % 2) == 1;
      total++;
      if ({busy_a, done_a, sclk_a, sdat_a, sld_a, busy_b, sclk_b, sld_b} !== 8'b0) begin
        bad++; $display("FAIL idle_outs cycle=%0d got=%b want=00000000", k,
                        {busy_a, done_a, sclk_a, sdat_a, sld_a, busy_b, sclk_b, sld_b});
      end
      total++;
      if (flash_a !== want) begin
        bad++; $display("FAIL flash cycle=%0d got=%b want=%b", k, flash_a, want);
      end
    end
  endtask

  task automatic test_single();
    logic [63:0] v, e, got;
    int fi, bi, li, d0;
    bit ok;
    v = 64'h8000_0000_0000_0001;
    fi = fr_a.size(); bi = bl_a.size(); li = ld_a.size(); d0 = dn_a;
    @(posedge clk); #1 seg_a = v; start_a = 1; exp_a.push_back(v);
    @(posedge clk); #1 start_a = 0;
    @(negedge clk);
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b want=1", busy_a); end
    wait_dn_a(d0 + 1, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got=0 want=1"); end
    repeat (20) @(posedge clk);
    total++;
    if (dn_a - d0 !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", dn_a - d0); end
    e = exp_a.size() > 0 ? exp_a.pop_front() : 64'h0;
    got = fr_a.size() > fi ? fr_a[fi] : 64'hx;
    total++;
    if (got !== e) begin bad++; $display("FAIL single_frame got=%h want=%h", got, e); end
    total++;
    if (nr_a.size() <= fi || nr_a[fi] != 64) begin
      bad++; $display("FAIL single_rises got=%0d want=64", nr_a.size() > fi ? nr_a[fi] : -1);
    end
    total++;
    if (bl_a.size() <= bi || bl_a[bi] != 260) begin
      bad++; $display("FAIL single_busy_len got=%0d want=260", bl_a.size() > bi ? bl_a[bi] : -1);
    end
    total++;
    if (ld_a.size() <= li || ld_a[li] != 4) begin
      bad++; $display("FAIL single_ld_len got=%0d want=4", ld_a.size() > li ? ld_a[li] : -1);
    end
  endtask

  task automatic test_integrity();
    logic [63:0] v, e, got;
    int fi, d0;
    bit ok;
    v = 64'hC0F9_A4B0_9992_82F8;
    fi = fr_a.size(); d0 = dn_a;
    @(posedge clk); #1 seg_a = v; start_a = 1; exp_a.push_back(v);
    @(posedge clk); #1 start_a = 0;
    repeat (40) @(posedge clk);
    #1 seg_a = 64'h0;
    wait_dn_a(d0 + 1, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL integrity_timeout got=0 want=1"); end
    repeat (5) @(posedge clk);
    e = exp_a.size() > 0 ? exp_a.pop_front() : 64'h0;
    got = fr_a.size() > fi ? fr_a[fi] : 64'hx;
    total++;
    if (got !== e) begin bad++; $display("FAIL integrity_frame got=%h want=%h", got, e); end
  endtask

  task automatic test_coalesce();
    logic [63:0] v, e, got;
    int fi, d0, n;
    bit ok;
    v = 64'h0123_4567_89AB_CDEF;
    fi = fr_a.size(); d0 = dn_a;
    @(posedge clk); #1 seg_a = v; start_a = 1;
    exp_a.push_back(v); exp_a.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1 start_a = 0;
    for (int p = 0; p < 3; p++) begin
      repeat (40) @(posedge clk);
      #1 start_a = 1;
      @(posedge clk); #1 start_a = 0;
    end
    repeat (20) @(posedge clk);
    #1 seg_a = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_dn_a(d0 + 2, 900, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL coalesce_timeout got=0 want=1"); end
    repeat (300) @(posedge clk);
    total++;
    if (dn_a - d0 !== 2) begin bad++; $display("FAIL coalesce_done_count got=%0d want=2", dn_a - d0); end
    for (int i = 0; i < 2; i++) begin
      e = exp_a.size() > 0 ? exp_a.pop_front() : 64'h0;
      got = fr_a.size() > fi + i ? fr_a[fi + i] : 64'hx;
      total++;
      if (got !== e) begin bad++; $display("FAIL coalesce_frame%0d got=%h want=%h", i, got, e); end
    end
    n = gp_a.size();
    total++;
    if (n == 0 || gp_a[n-1] != 1) begin
      bad++; $display("FAIL coalesce_gap got=%0d want=1", n > 0 ? gp_a[n-1] : -1);
    end
    n = bl_a.size();
    total++;
    if (n < 2 || bl_a[n-1] != 260 || bl_a[n-2] != 260) begin
      bad++; $display("FAIL coalesce_busy_len got=%0d want=260", n > 0 ? bl_a[n-1] : -1);
    end
  endtask

  task automatic test_abort();
    logic [63:0] v, e, got;
    int fi, d0;
    bit ok;
    fi = fr_a.size(); d0 = dn_a;
    @(posedge clk); #1 seg_a = 64'hDEAD_BEEF_0BAD_F00D; start_a = 1;
    @(posedge clk); #1 start_a = 0;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk);
      if (nra >= 20) ok = 1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL abort_wait got=%0d want=20", nra); end
    #1 rst_n = 0;
    #1;
    total++;
    if ({busy_a, done_a, sclk_a, sdat_a, sld_a} !== 5'b0) begin
      bad++; $display("FAIL abort_outs got=%b want=00000", {busy_a, done_a, sclk_a, sdat_a, sld_a});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (300) @(posedge clk);
    total++;
    if (dn_a != d0 || fr_a.size() != fi) begin
      bad++; $display("FAIL abort_no_done got=%0d/%0d want=%0d/%0d", dn_a, fr_a.size(), d0, fi);
    end
    v = 64'h5A5A_C3C3_1234_FEDC;
    @(posedge clk); #1 seg_a = v; start_a = 1; exp_a.push_back(v);
    @(posedge clk); #1 start_a = 0;
    wait_dn_a(d0 + 1, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_clean_timeout got=0 want=1"); end
    repeat (5) @(posedge clk);
    e = exp_a.size() > 0 ? exp_a.pop_front() : 64'h0;
    got = fr_a.size() > fi ? fr_a[fi] : 64'hx;
    total++;
    if (got !== e) begin bad++; $display("FAIL abort_clean_frame got=%h want=%h", got, e); end
    total++;
    if (nr_a.size() <= fi || nr_a[fi] != 64) begin
      bad++; $display("FAIL abort_clean_rises got=%0d want=64", nr_a.size() > fi ? nr_a[fi] : -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v, e, got;
    int fi, bi, si, gi, d0;
    bit ok;
    v = 64'hA5A5_0F0F_3C3C_9669;
    fi = fr_b.size(); bi = bl_b.size(); si = sp_b.size(); gi = gp_b.size(); d0 = dn_b;
    @(posedge clk); #1 seg_b = v; start_b = 1;
    for (int i = 0; i < 3; i++) exp_b.push_back(v);
    wait_dn_b(d0 + 1, 400, ok);
    repeat (5) @(posedge clk);
    #1 start_b = 0;
    wait_dn_b(d0 + 3, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d want=3", dn_b - d0); end
    repeat (300) @(posedge clk);
    total++;
    if (dn_b - d0 !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", dn_b - d0); end
    for (int i = 0; i < 3; i++) begin
      e = exp_b.size() > 0 ? exp_b.pop_front() : 64'h0;
      got = fr_b.size() > fi + i ? fr_b[fi + i] : 64'hx;
      total++;
      if (got !== e) begin bad++; $display("FAIL b2b_frame%0d got=%h want=%h", i, got, e); end
      total++;
      if (bl_b.size() <= bi + i || bl_b[bi + i] != 130) begin
        bad++; $display("FAIL b2b_busy_len%0d got=%0d want=130", i, bl_b.size() > bi + i ? bl_b[bi + i] : -1);
      end
      total++;
      if (sp_b.size() <= si + i || sp_b[si + i] != 126 || nr_b[si + i] != 64) begin
        bad++; $display("FAIL b2b_sclk_span%0d got=%0d want=126", i, sp_b.size() > si + i ? sp_b[si + i] : -1);
      end
    end
    total++;
    if (gp_b.size() != gi + 2 || gp_b[gi] != 1 || gp_b[gi + 1] != 1) begin
      bad++; $display("FAIL b2b_gap got=%0d want=1", gp_b.size() > gi ? gp_b[gi] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_integrity();
    test_coalesce();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_serial_ctrl.md
Name: seg7_serial_ctrl

Overview:
Sequencer between the 8-digit hex-to-segment encoder and the board's serial 7-segment shift-register chain. It captures the 64-bit segment word on request and shifts it out MSB-first on a divided serial clock, then pulses a latch strobe. It also generates the free-running blink signal that gates the encoder's per-digit enables.

Parameters:
CLK_DIV, 2, system clocks per serial-clock half period (>=1)
FLASH_DIV, 25000000, system clocks per blink half period (>=1)
WIDTH, 64, bits per frame (segment word width)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  WIDTH  segment word from encoder (bit 8k+0..7 = digit k a..g,p)
start  input  1  request a frame transfer; level sampled each clk
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion
flash  output  1  blink square wave to encoder (1 = blank enabled-for-blink digits)
s_clk  output  1  serial clock to shift chain, data sampled by chain on rising edge
s_dat  output  1  serial data
s_ld  output  1  latch/output-enable strobe after last bit

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE; busy, done, s_clk, s_dat, s_ld, flash = 0; shift reg, divider, bit counter, pending flag, flash counter = 0. Release mid-frame aborts; no partial latch.
- Divider: tick every CLK_DIV cycles while not IDLE; restarted to 0 on frame entry.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: start=1 at edge N -> seg_in captured into shift reg at edge N, FSM=SHIFT_LO, busy=1 from cycle N+1, bit counter = WIDTH-1.
- SHIFT_LO (CLK_DIV cycles): s_clk=0, s_dat=shreg[WIDTH-1] (stable whole bit). On tick -> SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): s_clk=1, s_dat held. On tick: shreg shifted left (zero fill); if bit counter=0 -> LATCH else counter-1, -> SHIFT_LO.
- LATCH (2*CLK_DIV cycles): s_clk=0, s_dat=0, s_ld=1. On end -> IDLE, busy=0, done=1 for exactly that first IDLE cycle.
- busy high for exactly (WIDTH+1)*2*CLK_DIV cycles per frame (260 at defaults); exactly WIDTH s_clk rising edges per frame.
- start while busy: sets pending (multiple requests coalesce to one). At done cycle, if pending: pending cleared, seg_in recaptured that edge, new frame begins (busy=1 next cycle). start in the done cycle itself is treated the same (one frame, not two).
- seg_in changes during a frame have no effect on it.
- flash: counter 0..FLASH_DIV-1, wraps, flash toggles on wrap; runs independent of FSM, period 2*FLASH_DIV cycles, first toggle FLASH_DIV cycles after reset release.
- Outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: hold rst_n=0, then release with start=0 for 100 cycles -> all outputs 0, s_clk never toggles; flash first goes 1 after FLASH_DIV cycles (bench FLASH_DIV=10: rises at cycle 10, falls at 20).
- Single frame, CLK_DIV=2: seg_in=64'h8000_0000_0000_0001, start pulse -> 64 s_clk rises; s_dat sampled at rises = 1, 62 zeros, 1; s_ld high 4 cycles; busy high 260 cycles; one done pulse.
- Data integrity: seg_in=64'hC0F9_A4B0_9992_82F8 ("01234567" encodings), change seg_in to 0 mid-frame -> bench shift-chain model holds C0F9A4B0999282F8 at s_ld.
- Coalesced requests: start pulsed 3 times during frame 1 with seg_in changed to 64'hFFFF_FFFF_FFFF_FFFF before done -> exactly one extra frame, busy rises cycle after done, frame 2 carries all ones; total done pulses = 2.
- Async abort: assert rst_n=0 after 20 bits shifted -> same cycle busy, s_clk, s_dat, s_ld = 0; no done; next start produces clean full 64-bit frame.
- CLK_DIV=1 corner: back-to-back start held high -> continuous frames, each 130 cycles busy with a 1-cycle done gap, s_clk period 2 cycles.
